// File: rtl/vga_sync_rx.sv
`default_nettype none
// ============================================================================
//  Module   : vga_sync_rx
//  Purpose  : Recovers pixel column/row position from active-low HSync/VSync,
//             tracks lock over consecutive well-formed frames and flags loss
//             of lock. Optional saturating error counter is built only when
//             VGA_SYNC_RX_ERR_COUNT_EN is defined (otherwise o_Err_Count = 0).
//  Revision : 1.0 - initial release
// ============================================================================
module vga_sync_rx #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_TOTAL     = 800,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_TOTAL     = 525,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_HSync,
    input  logic       i_VSync,
    output logic [9:0] o_Col_Count,
    output logic [9:0] o_Row_Count,
    output logic       o_Active,
    output logic       o_Frame_Start,
    output logic       o_Locked,
    output logic       o_Sync_Error,
    output logic [7:0] o_Err_Count
);

    localparam logic [9:0] c_COL_LOAD = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] c_ROW_LOAD = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] c_COL_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] c_ROW_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] c_H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] c_V_ACT    = 10'(V_ACTIVE);
    localparam logic [3:0] c_LOCK     = 4'(LOCK_FRAMES);
    localparam int         c_TO_LIMIT = 2 * H_TOTAL;
    localparam int         c_TO_W     = $clog2(c_TO_LIMIT + 1);
    localparam logic [c_TO_W-1:0] c_TO_MAX = c_TO_W'(c_TO_LIMIT);
    localparam logic [c_TO_W-1:0] c_TO_ONE = c_TO_W'(1);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [3:0]          r_good;
    logic [3:0]          w_good_next;
    logic                w_err;
    logic                r_hs_d;
    logic                r_vs_d;
    logic [9:0]          r_col;
    logic [9:0]          r_row;
    logic [c_TO_W-1:0]   r_to_cnt;

    logic                w_hs_fall;
    logic                w_vs_fall;
    logic                w_col_wrap;
    logic [9:0]          w_col_fr;
    logic [9:0]          w_row_fr;
    logic                w_hs_mis;
    logic                w_vs_mis;
    logic                w_timeout;
    logic                w_locked;

    // Edge detect compares the registered history against the live input
    assign w_hs_fall  = r_hs_d & ~i_HSync;
    assign w_vs_fall  = r_vs_d & ~i_VSync;

    // Free-running positions; the row only advances when the column really
    // wraps, i.e. an HSync load on the last column suppresses the increment.
    assign w_col_wrap = (r_col == c_COL_LAST) && !w_hs_fall;
    assign w_col_fr   = (r_col == c_COL_LAST) ? 10'd0 : r_col + 10'd1;
    assign w_row_fr   = w_col_wrap ? ((r_row == c_ROW_LAST) ? 10'd0 : r_row + 10'd1)
                                   : r_row;

    // A sync edge is a mismatch when its load differs from the free-run value
    assign w_hs_mis   = w_hs_fall && (w_col_fr != c_COL_LOAD);
    assign w_vs_mis   = w_vs_fall && (w_row_fr != c_ROW_LOAD);
    assign w_timeout  = (r_to_cnt == c_TO_MAX);
    assign w_locked   = (r_state == ST_LOCKED);

    // Sync history registers, idle-high so reset never fabricates an edge
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_hs_d <= 1'b1;
            r_vs_d <= 1'b1;
        end else begin
            r_hs_d <= i_HSync;
            r_vs_d <= i_VSync;
        end
    end

    // Position counters: free-run, overridden by sync-edge loads in any state
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_col <= 10'd0;
            r_row <= 10'd0;
        end else begin
            r_col <= w_hs_fall ? c_COL_LOAD : w_col_fr;
            r_row <= w_vs_fall ? c_ROW_LOAD : w_row_fr;
        end
    end

    // Clocks since the last HSync edge, saturating at the timeout threshold
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_to_cnt <= '0;
        end else if (w_hs_fall) begin
            r_to_cnt <= '0;
        end else if (!w_timeout) begin
            r_to_cnt <= r_to_cnt + c_TO_ONE;
        end
    end

    // Lock tracker state and good-frame count
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_state <= ST_UNLOCKED;
            r_good  <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_good  <= w_good_next;
        end
    end

    // Next-state and error-pulse decision; a stalled HSync overrides all
    always_comb begin
        w_state_next = r_state;
        w_good_next  = r_good;
        w_err        = 1'b0;
        case (r_state)
            ST_UNLOCKED: begin
                if (w_vs_fall) begin
                    w_state_next = ST_ACQUIRE;
                    w_good_next  = 4'd0;
                end
            end
            ST_ACQUIRE: begin
                if (w_hs_mis || w_vs_mis) begin
                    w_good_next = 4'd0;
                end else if (w_vs_fall) begin
                    w_good_next = r_good + 4'd1;
                    if (r_good + 4'd1 == c_LOCK) begin
                        w_state_next = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                if (w_hs_mis || w_vs_mis) begin
                    w_state_next = ST_UNLOCKED;
                    w_err        = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_UNLOCKED;
            end
        endcase
        if (w_timeout) begin
            w_state_next = ST_UNLOCKED;
            w_good_next  = 4'd0;
            w_err        = w_locked;
        end
    end

    // Output register stage, one clock behind the position counters
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            o_Col_Count   <= 10'd0;
            o_Row_Count   <= 10'd0;
            o_Active      <= 1'b0;
            o_Frame_Start <= 1'b0;
            o_Locked      <= 1'b0;
            o_Sync_Error  <= 1'b0;
        end else begin
            o_Col_Count   <= r_col;
            o_Row_Count   <= r_row;
            o_Active      <= w_locked && (r_col < c_H_ACT) && (r_row < c_V_ACT);
            o_Frame_Start <= w_locked && (r_col == 10'd0) && (r_row == 10'd0);
            o_Locked      <= w_locked;
            o_Sync_Error  <= w_err;
        end
    end

`ifdef VGA_SYNC_RX_ERR_COUNT_EN
    logic [7:0] r_err_cnt;

    // Saturating tally of lock-loss events, updated with the error pulse
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_err_cnt <= 8'd0;
        end else if (w_err && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign o_Err_Count = r_err_cnt;
`else
    assign o_Err_Count = 8'd0;
`endif

endmodule
`default_nettype wire

// File: doc/vga_sync_rx.md
VGA_SYNC_RX -- requirements
Module: vga_sync_rx

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FP, default 16, horizontal front porch in clocks.
REQ-003 Parameter H_TOTAL, default 800, clocks per line.
REQ-004 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-005 Parameter V_FP, default 10, vertical front porch in lines.
REQ-006 Parameter V_TOTAL, default 525, lines per frame.
REQ-007 Parameter LOCK_FRAMES, default 2, consecutive good frames required to lock, range 1..15.
REQ-008 Port i_Clk, input, 1, single clock; all logic SHALL be on its rising edge.
REQ-009 Port i_Reset, input, 1, asynchronous active-high reset.
REQ-010 Port i_HSync, input, 1, active-low horizontal sync, synchronous to i_Clk.
REQ-011 Port i_VSync, input, 1, active-low vertical sync, synchronous to i_Clk.
REQ-012 Port o_Col_Count, output, 10, recovered column, where 0 is the first visible pixel.
REQ-013 Port o_Row_Count, output, 10, recovered row, where 0 is the first visible line.
REQ-014 Port o_Active, output, 1, high when locked and col < H_ACTIVE and row < V_ACTIVE.
REQ-015 Port o_Frame_Start, output, 1, one-clock pulse when the counters become (0,0) while locked.
REQ-016 Port o_Locked, output, 1, high in state LOCKED.
REQ-017 Port o_Sync_Error, output, 1, one-clock pulse on loss of lock.
REQ-018 Port o_Err_Count, output, 8, saturating count of o_Sync_Error pulses.

Function
REQ-019 Each sync input SHALL be registered once; a falling edge is detected when the previous registered value is 1 and the current input is 0.
REQ-020 Col/row counters SHALL free-run:
- col wraps from H_TOTAL-1 to 0;
- on that wrap, row increments;
- row wraps from V_TOTAL-1 to 0.
REQ-021 On an HSync falling edge, col SHALL load H_ACTIVE+H_FP (656) in the same cycle the edge is detected, overriding free-run.
REQ-022 On a VSync falling edge, row SHALL load V_ACTIVE+V_FP (490); this load takes priority over the row increment in the same cycle.
REQ-023 Simultaneous HSync and VSync edges SHALL apply both loads in the same cycle.
REQ-024 An edge is "matching" when its load value equals the value the counter would have taken by free-running; otherwise it is a "mismatch".
REQ-025 State machine states are UNLOCKED, ACQUIRE and LOCKED.
REQ-026 UNLOCKED: the first VSync edge moves to ACQUIRE and clears the good-frame count.
REQ-027 ACQUIRE:
- each matching VSync edge increments the good-frame count;
- any mismatch clears the count and the state remains ACQUIRE;
- when the count reaches LOCK_FRAMES, the state moves to LOCKED.
REQ-028 LOCKED: any mismatching HSync or VSync edge SHALL pulse o_Sync_Error and move to UNLOCKED.
REQ-029 Timeout: no HSync edge for 2*H_TOTAL consecutive clocks SHALL move any state to UNLOCKED; o_Sync_Error pulses only if the state was LOCKED.
REQ-030 Counters SHALL continue loading on edges in every state; the UNLOCKED and ACQUIRE states only gate o_Active and o_Frame_Start low.
REQ-031 All outputs SHALL be registered, with one clock of latency from counter update.

Reset
REQ-032 While i_Reset is high:
- col, row, o_Err_Count and the good-frame count are 0;
- the state is UNLOCKED;
- all 1-bit outputs are 0;
- the sync history registers are 1.
REQ-033 Reset asserted mid-frame SHALL take effect immediately; after release, lock SHALL require a fresh ACQUIRE sequence.

Configuration
REQ-034 When macro VGA_SYNC_RX_ERR_COUNT_EN is defined, o_Err_Count SHALL increment on each o_Sync_Error pulse and saturate at 255.
REQ-035 When the macro is undefined, o_Err_Count SHALL be tied to 0 and no counter logic is generated; all other behaviour is unchanged.

Verification
REQ-036 Clean 640x480 timing for 3 frames after reset -> o_Locked rises at the 3rd VSync edge (LOCK_FRAMES=2); o_Frame_Start pulses once per frame thereafter.
REQ-037 While locked, one HSync edge delayed by 1 clock -> o_Sync_Error pulses once, o_Locked falls, and o_Err_Count = 1 when the macro is defined (0 when undefined).
REQ-038 While locked, HSync held high for 1600 clocks -> timeout, o_Locked = 0 and o_Sync_Error pulses once.
REQ-039 While locked, pixel at line start 0 + 35 + 100 clocks -> o_Col_Count = 100, o_Row_Count = 0, o_Active = 1; at col 700 -> o_Active = 0.
REQ-040 Reset pulsed mid-frame while locked -> all outputs 0 immediately; relock occurs after 3 VSync edges.
REQ-041 Stimulus of 260 forced mismatches with the macro defined -> o_Err_Count saturates at 255.
